// File: rtl/lc3_pkg.sv
// Shared LC-3 definitions for the operand-fetch stage and its register file.
package lc3_pkg;

  typedef enum logic [1:0] {
    ALUK_ADD  = 2'b00,
    ALUK_AND  = 2'b01,
    ALUK_NOT  = 2'b10,
    ALUK_PASS = 2'b11
  } aluk_t;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [2:0] {
    NZP_P = 3'b001,
    NZP_Z = 3'b010,
    NZP_N = 3'b100
  } nzp_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  function automatic logic [15:0] sext5(input logic [4:0] imm);
    return {{11{imm[4]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// LC-3 register file: 8 x 16, two combinational read ports, one synchronous write port.
module register_file
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  rd_a_addr,
  output logic [15:0] rd_a_data,
  input  logic [2:0]  rd_b_addr,
  output logic [15:0] rd_b_data,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data
);

  logic [7:0][15:0] mem_q;
  logic [7:0][15:0] mem_d;

  // Next array contents: overwrite the addressed entry on a write strobe.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Storage, cleared to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_a_data = mem_q[rd_a_addr];
  assign rd_b_data = mem_q[rd_b_addr];

endmodule

// File: rtl/alu_operand_fetch.sv
// Operand-fetch stage feeding the LC-3 ALU: decode, register read with writeback
// bypass, scoreboard stall, registered ALU operands and NZP condition codes.
module alu_operand_fetch
  import lc3_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] ir,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  aluk,
  output logic [15:0] A,
  output logic [15:0] B,
  output logic [2:0]  dr,
  input  logic        wb_en,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic [2:0]  nzp,
  output logic        illegal
);

  logic [3:0]  opcode;
  logic [2:0]  f_dr, f_sr1, f_sr2;
  logic        f_imm;
  logic        is_add, is_and, is_not, legal, use_sr2;
  logic [15:0] rf_a, rf_b, src1_val, src2_val;
  logic [7:0]  wb_mask, pend_eff;
  logic        hazard, accept, load;

  out_state_t  state_q, state_d;
  logic [7:0]  pending_q, pending_d;
  aluk_t       aluk_q, aluk_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [2:0]  dr_q, dr_d;
  nzp_t        nzp_q, nzp_d;
  logic        illegal_q, illegal_d;

  register_file u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_a_addr (f_sr1),
    .rd_a_data (rf_a),
    .rd_b_addr (f_sr2),
    .rd_b_data (rf_b),
    .wr_en     (wb_en),
    .wr_addr   (wb_dr),
    .wr_data   (wb_data)
  );

  // Decode fields, bypass sources, and resolve the hazard/handshake.
  always_comb begin
    opcode  = ir[15:12];
    f_dr    = ir[11:9];
    f_sr1   = ir[8:6];
    f_sr2   = ir[2:0];
    f_imm   = ir[5];
    is_add  = (opcode == OP_ADD);
    is_and  = (opcode == OP_AND);
    is_not  = (opcode == OP_NOT);
    legal   = is_add | is_and | is_not;
    use_sr2 = (is_add | is_and) & ~f_imm;

    src1_val = (wb_en && (wb_dr == f_sr1)) ? wb_data : rf_a;
    src2_val = (wb_en && (wb_dr == f_sr2)) ? wb_data : rf_b;

    // A writeback landing this cycle retires its pending bit for hazard purposes.
    wb_mask  = wb_en ? (8'b1 << wb_dr) : '0;
    pend_eff = pending_q & ~wb_mask;
    hazard   = legal & (pend_eff[f_sr1] | (use_sr2 & pend_eff[f_sr2]) | pend_eff[f_dr]);

    in_ready = ((state_q == OUT_EMPTY) | out_ready) & ~hazard;
    accept   = in_valid & in_ready;
    load     = accept & legal;
  end

  // Output-register FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: if (load) state_d = OUT_FULL;
      OUT_FULL:  if (out_ready && !load) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Output-register FSM outputs.
  always_comb begin
    out_valid = (state_q == OUT_FULL);
  end

  // Operand, scoreboard, condition-code and illegal-pulse next values.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    aluk_d = aluk_q;
    dr_d   = dr_q;
    if (load) begin
      a_d  = src1_val;
      dr_d = f_dr;
      if (is_and)      aluk_d = ALUK_AND;
      else if (is_not) aluk_d = ALUK_NOT;
      else             aluk_d = ALUK_ADD;
      if (is_not)      b_d = '0;
      else if (f_imm)  b_d = sext5(ir[4:0]);
      else             b_d = src2_val;
    end

    // Clear first, then set, so a same-cycle set on the same register wins.
    pending_d = pending_q & ~wb_mask;
    if (load) begin
      pending_d[f_dr] = 1'b1;
    end

    nzp_d = nzp_q;
    if (wb_en) begin
      if (wb_data[15])          nzp_d = NZP_N;
      else if (wb_data == '0)   nzp_d = NZP_Z;
      else                      nzp_d = NZP_P;
    end

    illegal_d = accept & ~legal;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OUT_EMPTY;
      pending_q <= '0;
      aluk_q    <= ALUK_ADD;
      a_q       <= '0;
      b_q       <= '0;
      dr_q      <= '0;
      nzp_q     <= NZP_Z;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      aluk_q    <= aluk_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dr_q      <= dr_d;
      nzp_q     <= nzp_d;
      illegal_q <= illegal_d;
    end
  end

  assign aluk    = aluk_q;
  assign A       = a_q;
  assign B       = b_q;
  assign dr      = dr_q;
  assign nzp     = nzp_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Testbench for alu_operand_fetch: directed vector table, reset-mid-operation
// sequence, then randomized traffic against a behavioural model.
module tb_alu_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] ir;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  aluk;
  logic [15:0] A;
  logic [15:0] B;
  logic [2:0]  dr;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic [2:0]  nzp;
  logic        illegal;

  alu_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ir        (ir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aluk      (aluk),
    .A         (A),
    .B         (B),
    .dr        (dr),
    .wb_en     (wb_en),
    .wb_dr     (wb_dr),
    .wb_data   (wb_data),
    .nzp       (nzp),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [15:0] ir;
    logic        ordy;
    logic        wbe;
    logic [2:0]  wbd;
    logic [15:0] wbv;
    logic        e_rdy;
    logic        e_ov;
    logic [1:0]  e_aluk;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [2:0]  e_dr;
    logic [2:0]  e_nzp;
    logic        e_ill;
  } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model state
  logic [15:0] m_regs [8];
  bit          m_pend [8];
  bit          m_full;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_aluk;
  logic [2:0]  m_dr, m_nzp;
  bit          m_ill;
  bit          m_rdy;

  task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) begin
      m_regs[r] = 16'h0;
      m_pend[r] = 1'b0;
    end
    m_full = 0; m_a = 0; m_b = 0; m_aluk = 0; m_dr = 0; m_nzp = 3'b010; m_ill = 0;
  endtask

  function automatic bit is_legal(input logic [15:0] w);
    return (w[15:12] == 4'd1) || (w[15:12] == 4'd5) || (w[15:12] == 4'd9);
  endfunction

  function automatic logic [15:0] src_val(input logic [2:0] r);
    return (wb_en && wb_dr == r) ? wb_data : m_regs[r];
  endfunction

  function automatic bit busy(input logic [2:0] r);
    return m_pend[r] && !(wb_en && wb_dr == r);
  endfunction

  // Acceptance decision from the current inputs and model state.
  task automatic model_comb();
    bit haz;
    bit uses2;
    uses2 = (ir[15:12] != 4'd9) && !ir[5];
    haz = is_legal(ir) && (busy(ir[8:6]) || (uses2 && busy(ir[2:0])) || busy(ir[11:9]));
    m_rdy = (!m_full || out_ready) && !haz;
  endtask

  // State update at the clock edge.
  task automatic model_edge();
    bit acc;
    acc = in_valid && m_rdy;
    if (acc && is_legal(ir)) begin
      m_a    = src_val(ir[8:6]);
      m_dr   = ir[11:9];
      m_aluk = (ir[15:12] == 4'd1) ? 2'd0 : (ir[15:12] == 4'd5) ? 2'd1 : 2'd2;
      if (ir[15:12] == 4'd9) m_b = 16'h0;
      else if (ir[5])        m_b = {{11{ir[4]}}, ir[4:0]};
      else                   m_b = src_val(ir[2:0]);
      m_full = 1;
    end else if (out_ready) begin
      m_full = 0;
    end
    m_ill = acc && !is_legal(ir);
    if (wb_en) begin
      m_regs[wb_dr] = wb_data;
      m_pend[wb_dr] = 0;
      m_nzp = wb_data[15] ? 3'b100 : (wb_data == 16'h0) ? 3'b010 : 3'b001;
    end
    if (acc && is_legal(ir)) m_pend[ir[11:9]] = 1;
  endtask

  // One clock: drive, check in_ready, clock, check registered outputs.
  task automatic cycle(input vec_t v, input bit use_tbl, input int idx);
    in_valid = v.iv; ir = v.ir; out_ready = v.ordy;
    wb_en = v.wbe; wb_dr = v.wbd; wb_data = v.wbv;
    #1;
    model_comb();
    chk("in_ready", idx, 16'(in_ready), 16'(use_tbl ? v.e_rdy : m_rdy));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_valid", idx, 16'(out_valid), 16'(use_tbl ? v.e_ov   : m_full));
    chk("aluk",      idx, 16'(aluk),      16'(use_tbl ? v.e_aluk : m_aluk));
    chk("A",         idx, A,              use_tbl ? v.e_a : m_a);
    chk("B",         idx, B,              use_tbl ? v.e_b : m_b);
    chk("dr",        idx, 16'(dr),        16'(use_tbl ? v.e_dr   : m_dr));
    chk("nzp",       idx, 16'(nzp),       16'(use_tbl ? v.e_nzp  : m_nzp));
    chk("illegal",   idx, 16'(illegal),   16'(use_tbl ? v.e_ill  : m_ill));
  endtask

  vec_t tbl [20];
  vec_t v;

  initial begin
    //          iv   ir        ordy wbe  wbd   wbv        rdy  ov   aluk  A         B         dr    nzp     ill
    tbl[0]  = '{1'b1, 16'h123D, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 16'hFFFD, 3'd1, 3'b010, 1'b0};
    tbl[1]  = '{1'b1, 16'h1461, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 16'hFFFD, 3'd1, 3'b010, 1'b0};
    tbl[2]  = '{1'b1, 16'h1461, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h0000, 16'hFFFD, 3'd1, 3'b010, 1'b0};
    tbl[3]  = '{1'b1, 16'h1461, 1'b1, 1'b1, 3'd1, 16'hFFFD, 1'b1, 1'b1, 2'd0, 16'hFFFD, 16'h0001, 3'd2, 3'b100, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd4, 16'h0F0F, 1'b1, 1'b0, 2'd0, 16'hFFFD, 16'h0001, 3'd2, 3'b001, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd5, 16'h00FF, 1'b1, 1'b0, 2'd0, 16'hFFFD, 16'h0001, 3'd2, 3'b001, 1'b0};
    tbl[6]  = '{1'b1, 16'h5705, 1'b1, 1'b1, 3'd2, 16'h0000, 1'b1, 1'b1, 2'd1, 16'h0F0F, 16'h00FF, 3'd3, 3'b010, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 3'd3, 16'h000F, 1'b1, 1'b0, 2'd1, 16'h0F0F, 16'h00FF, 3'd3, 3'b001, 1'b0};
    tbl[8]  = '{1'b1, 16'h1921, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0F0F, 16'h0001, 3'd4, 3'b001, 1'b0};
    tbl[9]  = '{1'b1, 16'h1D45, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 16'h0F0F, 16'h0001, 3'd4, 3'b001, 1'b0};
    tbl[10] = '{1'b1, 16'h1D45, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 16'h0F0F, 16'h0001, 3'd4, 3'b001, 1'b0};
    tbl[11] = '{1'b1, 16'h1D45, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 16'h0F0F, 16'h0001, 3'd4, 3'b001, 1'b0};
    tbl[12] = '{1'b1, 16'h1D45, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 16'h0F0F, 16'h0001, 3'd4, 3'b001, 1'b0};
    tbl[13] = '{1'b1, 16'h1D45, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h00FF, 16'h00FF, 3'd6, 3'b001, 1'b0};
    tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h00FF, 16'h00FF, 3'd6, 3'b001, 1'b0};
    tbl[15] = '{1'b1, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 2'd0, 16'h00FF, 16'h00FF, 3'd6, 3'b001, 1'b1};
    tbl[16] = '{1'b1, 16'h1020, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 3'd0, 3'b001, 1'b0};
    tbl[17] = '{1'b1, 16'h9DFF, 1'b1, 1'b1, 3'd6, 16'h8000, 1'b1, 1'b1, 2'd2, 16'h0000, 16'h0000, 3'd6, 3'b100, 1'b0};
    tbl[18] = '{1'b1, 16'h1BA0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 2'd2, 16'h0000, 16'h0000, 3'd6, 3'b100, 1'b0};
    tbl[19] = '{1'b1, 16'h13E0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 3'd1, 3'b100, 1'b0};

    rst_n = 1'b0; in_valid = 0; ir = 0; out_ready = 0; wb_en = 0; wb_dr = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("rst out_valid", -1, 16'(out_valid), 16'h0);
    chk("rst A",         -1, A,              16'h0);
    chk("rst B",         -1, B,              16'h0);
    chk("rst aluk",      -1, 16'(aluk),      16'h0);
    chk("rst dr",        -1, 16'(dr),        16'h0);
    chk("rst nzp",       -1, 16'(nzp),       16'h2);
    chk("rst illegal",   -1, 16'(illegal),   16'h0);

    for (int i = 0; i < 20; i++) cycle(tbl[i], 1'b1, i);

    // Reset while FULL with R1 pending: outputs clear without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", 100, 16'(out_valid), 16'h0);
    chk("midrst dr",        100, 16'(dr),        16'h0);
    chk("midrst nzp",       100, 16'(nzp),       16'h2);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    v = '{1'b1, 16'h1460, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 3'd2, 3'b010, 1'b0};
    cycle(v, 1'b1, 101);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int unsigned r;
      logic [3:0] op;
      r = $urandom_range(0, 9);
      if (r < 3)      op = 4'd1;
      else if (r < 6) op = 4'd5;
      else if (r < 8) op = 4'd9;
      else begin
        op = 4'($urandom_range(0, 15));
        if (op == 4'd1 || op == 4'd5 || op == 4'd9) op = 4'hF;
      end
      v.iv   = ($urandom_range(0, 3) != 0);
      v.ir   = {op, 12'($urandom)};
      v.ordy = ($urandom_range(0, 3) != 0);
      v.wbe  = ($urandom_range(0, 2) != 0);
      v.wbd  = 3'($urandom);
      v.wbv  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      cycle(v, 1'b0, 200 + i);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_operand_fetch.md
# alu_operand_fetch

Operand-fetch stage directly upstream of the LC-3 ALU. Accepts ADD/AND/NOT instruction words over a valid/ready handshake, reads the 8×16 register file, sign-extends imm5, and presents registered `aluk`/`A`/`B`/`dr` to the ALU. Accepts the ALU result back as a writeback, updating the register file and NZP condition codes, and tracks in-flight destinations with a scoreboard so dependent instructions stall.

## Interface
- No parameters: 16-bit datapath, 8 registers, fixed by the LC-3 ISA.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `in_valid` in 1: `ir` holds an instruction.
- `in_ready` out 1: stage can accept `ir` this cycle.
- `ir` in 16: instruction word.
- `out_valid` out 1: `aluk`/`A`/`B`/`dr` valid.
- `out_ready` in 1: ALU side consumes this cycle.
- `aluk` out 2: 00 ADD, 01 AND, 10 NOT, 11 pass.
- `A` out 16: SR1 value.
- `B` out 16: SR2 value or sext(imm5).
- `dr` out 3: destination register.
- `wb_en` in 1: writeback strobe.
- `wb_dr` in 3: writeback register.
- `wb_data` in 16: writeback value (ALU `S`).
- `nzp` out 3: condition codes {N,Z,P}.
- `illegal` out 1: one-cycle pulse when a non-ADD/AND/NOT word is accepted.

## Operation
- Decode, with opcode = `ir[15:12]`:
  - 0001 ADD → `aluk`=00.
  - 0101 AND → `aluk`=01.
  - 1001 NOT → `aluk`=10, B=0.
  - Anything else is accepted, discarded, and pulses `illegal` the next cycle. It does not touch the output register or scoreboard.
- Fields: DR=`ir[11:9]`, SR1=`ir[8:6]`. If `ir[5]`=1, B=sign-extend(`ir[4:0]`) to 16 bits; otherwise B=R[`ir[2:0]`] (SR2).
- Scoreboard: 8 pending bits.
  - Set `pending[DR]` when a legal instruction transfers in.
  - Clear `pending[wb_dr]` on `wb_en`.
  - Same register set and cleared in one cycle: set wins.
- Hazard when any of these is pending after masking out a same-cycle `wb_dr` clear: SR1, SR2 (only if `ir[5]`=0 and opcode ADD/AND), or DR. NOT ignores SR2.
- Bypass: if `wb_en` and `wb_dr` equals a source in the transfer cycle, use `wb_data` instead of the array value.
- Writeback:
  - R[`wb_dr`] ← `wb_data`.
  - `nzp` ← 100 if `wb_data[15]`, 010 if zero, else 001. Exactly one bit is always set.
- Output register: two-state FSM.
  - EMPTY → FULL on transfer-in.
  - FULL → EMPTY on `out_ready` with no transfer-in.
  - FULL → FULL on `out_ready` with transfer-in (new contents).
  - `out_valid` = (state==FULL).
- `aluk`=11 is never produced by decode; it is reserved for other datapath users.

## Timing
- `in_ready` = (EMPTY or `out_ready`) and no hazard. Combinational; may depend on `ir`, `wb_en`, `wb_dr`.
- Transfer-in on `in_valid && in_ready`. `A`/`B`/`aluk`/`dr` update at that edge, so latency is 1 cycle. Output is stable while `out_valid && !out_ready`.
- Writeback takes effect at the edge: visible in the array, `nzp`, and scoreboard the next cycle. Same-cycle reads use the bypass.
- Throughput: 1 instruction/cycle with independent registers.
- Reset values:
  - `out_valid`=0, `A`=`B`=0, `aluk`=00, `dr`=0.
  - `nzp`=010, `illegal`=0.
  - All registers 0, all pending 0.
  - Reset mid-operation drops the held instruction and clears the scoreboard.

## Structure
- Shared package `lc3_pkg`:
  - `aluk_t` enum (ADD, AND, NOT, PASS).
  - Opcode constants `OP_ADD`/`OP_AND`/`OP_NOT`.
  - `nzp_t`.
  - `sext5` function.
- Sub-module `register_file`: 8×16, two combinational read ports, one synchronous write port, async active-low reset to 0. Bypass and scoreboard stay in the parent.

## Test plan
- Reset, then ADD R1,R0,#-3 (0x123D) with `out_ready`=1:
  - Next cycle `out_valid`=1, `aluk`=00, `A`=0x0000, `B`=0xFFFD, `dr`=1.
  - Writeback 0xFFFD → R1 gives `nzp`=100.
- Back-to-back ADD R2,R1,#1 right after the above, with writeback delayed 3 cycles: `in_ready`=0 until the `wb_en` cycle. Transfer happens in that cycle with `A`=0xFFFD via bypass.
- AND R3,R4,R5 (0x5705) with R4=0x0F0F, R5=0x00FF: `aluk`=01, `A`=0x0F0F, `B`=0x00FF. Writeback 0x000F gives `nzp`=001.
- Backpressure: `out_ready`=0 for 4 cycles with FULL and `in_valid`=1. Outputs hold, `in_ready`=0. Releasing `out_ready` for one cycle swaps in the next instruction.
- Illegal 0x0000 accepted: `illegal` pulses 1 cycle, `out_valid` and scoreboard unchanged. NOT R6,R7 (0x9DFF) gives `aluk`=10, `dr`=6.
- Assert `rst_n`=0 while FULL with pending[1]=1: `out_valid`=0 and pending clear immediately. After release, ADD R2,R1,#0 is accepted on the first cycle.
